// File: rtl/down_counter_timer_pkg.sv
// Shared types and defaults for the loadable down-counter timer.
package down_counter_timer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sub_bout.sv
// WIDTH-bit subtract with borrow-out: O = I0 - I1, BOUT set when I1 > I0.
// Purely combinational, zero latency, no flow control.
// Borrow counterpart of the adder with carry-out.
module sub_bout #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    output logic [WIDTH-1:0] O,
    output logic             BOUT
);

    logic [WIDTH:0] diff;

    // The extra top bit catches the borrow out of the WIDTH-bit difference.
    assign diff = {1'b0, I0} - {1'b0, I1};
    assign O    = diff[WIDTH-1:0];
    assign BOUT = diff[WIDTH];

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter: counts enabled cycles to zero, pulses BOUT on borrow, one-shot or periodic.
// Load visible on O one cycle after the accepting edge; BOUT high the cycle after the borrow edge.
// LOAD_READY only while IDLE; LOAD_VALID is ignored (must be held) while RUN.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             PERIODIC,
    input  logic             EN,
    output logic [WIDTH-1:0] O,
    output logic             BOUT,
    output logic             BUSY
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             bout_q, bout_d;

    logic [WIDTH-1:0] dec_val;
    logic             dec_borrow;

    sub_bout #(
        .WIDTH (WIDTH)
    ) u_sub_bout (
        .I0   (count_q),
        .I1   (WIDTH'(1)),
        .O    (dec_val),
        .BOUT (dec_borrow)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        bout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (LOAD_VALID) begin
                    count_d  = LOAD_DATA;
                    reload_d = LOAD_DATA;
                    mode_d   = PERIODIC;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (EN) begin
                    if (dec_borrow) begin
                        bout_d = 1'b1;
                        // One-shot parks at zero rather than wrapping to all-ones.
                        if (mode_q) begin
                            count_d = reload_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = dec_val;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            bout_q   <= bout_d;
        end
    end

    assign O          = count_q;
    assign BOUT       = bout_q;
    assign BUSY       = (state_q == RUN);
    assign LOAD_READY = (state_q == IDLE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (WIDTH=4).
module tb_down_counter_timer;

    localparam int W = 4;

    logic         CLK;
    logic         RESETN;
    logic         LOAD_VALID;
    logic         LOAD_READY;
    logic [W-1:0] LOAD_DATA;
    logic         PERIODIC;
    logic         EN;
    logic [W-1:0] O;
    logic         BOUT;
    logic         BUSY;

    int errors = 0;
    int checks = 0;

    down_counter_timer #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .LOAD_DATA  (LOAD_DATA),
        .PERIODIC   (PERIODIC),
        .EN         (EN),
        .O          (O),
        .BOUT       (BOUT),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        #3;
        RESETN = 1'b1;
        tick();
    endtask

    task automatic do_load(input logic [W-1:0] data, input logic per);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = data;
        PERIODIC   = per;
        tick();
        LOAD_VALID = 1'b0;
        checks++;
        if (O !== data || BUSY !== 1'b1 || LOAD_READY !== 1'b0) begin
            errors++;
            $display("FAIL load: O=%0d BUSY=%b RDY=%b, expected O=%0d BUSY=1 RDY=0", O, BUSY, LOAD_READY, data);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (O !== 4'd0 || BOUT !== 1'b0 || BUSY !== 1'b0 || LOAD_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_init: O=%0d BOUT=%b BUSY=%b RDY=%b, expected 0 0 0 1", O, BOUT, BUSY, LOAD_READY);
        end
        EN = 1'b0;
        do_load(4'd5, 1'b0);
        tick();
        checks++;
        if (O !== 4'd5 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL hold_en0: O=%0d BUSY=%b, expected 5 1", O, BUSY);
        end
        #2;
        RESETN = 1'b0;
        #1;
        checks++;
        if (O !== 4'd0 || BOUT !== 1'b0 || BUSY !== 1'b0 || LOAD_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: O=%0d BOUT=%b BUSY=%b RDY=%b, expected 0 0 0 1", O, BOUT, BUSY, LOAD_READY);
        end
        RESETN = 1'b1;
        tick();
    endtask

    task automatic test_one_shot();
        logic [W-1:0] exp_o [3] = '{4'd2, 4'd1, 4'd0};
        EN = 1'b1;
        do_load(4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (O !== exp_o[i] || BOUT !== 1'b0 || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL one_shot_count[%0d]: O=%0d BOUT=%b BUSY=%b, expected O=%0d 0 1", i, O, BOUT, BUSY, exp_o[i]);
            end
        end
        tick();
        checks++;
        if (BOUT !== 1'b1 || BUSY !== 1'b0 || LOAD_READY !== 1'b1 || O !== 4'd0) begin
            errors++;
            $display("FAIL one_shot_bout: O=%0d BOUT=%b BUSY=%b RDY=%b, expected 0 1 0 1", O, BOUT, BUSY, LOAD_READY);
        end
        tick();
        checks++;
        if (BOUT !== 1'b0 || O !== 4'd0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL one_shot_after: O=%0d BOUT=%b BUSY=%b, expected 0 0 0", O, BOUT, BUSY);
        end
    endtask

    task automatic test_periodic();
        logic [W-1:0] exp_o [3] = '{4'd1, 4'd0, 4'd2};
        EN = 1'b1;
        do_load(4'd2, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (O !== exp_o[i % 3] || BOUT !== (i % 3 == 2) || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL periodic[%0d]: O=%0d BOUT=%b BUSY=%b, expected O=%0d BOUT=%b 1",
                         i, O, BOUT, BUSY, exp_o[i % 3], (i % 3 == 2));
            end
        end
        do_reset();
    endtask

    task automatic test_enable_gaps();
        logic         en_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] exp_o  [4] = '{4'd1, 4'd1, 4'd0, 4'd0};
        EN = 1'b1;
        do_load(4'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            EN = en_seq[i];
            tick();
            if (i < 4) begin
                checks++;
                if (O !== exp_o[i] || BOUT !== 1'b0) begin
                    errors++;
                    $display("FAIL en_gap[%0d]: O=%0d BOUT=%b, expected O=%0d 0", i, O, BOUT, exp_o[i]);
                end
            end
        end
        checks++;
        if (BOUT !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL en_gap_bout: BOUT=%b BUSY=%b, expected 1 0", BOUT, BUSY);
        end
        EN = 1'b1;
    endtask

    task automatic test_back_to_back();
        EN = 1'b1;
        do_load(4'd1, 1'b0);
        // Valid stays high with new data throughout RUN.
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 4'd9;
        tick();
        checks++;
        if (O !== 4'd0 || LOAD_READY !== 1'b0 || BOUT !== 1'b0) begin
            errors++;
            $display("FAIL hs_hold: O=%0d RDY=%b BOUT=%b, expected 0 0 0", O, LOAD_READY, BOUT);
        end
        tick();
        checks++;
        if (O !== 4'd0 || LOAD_READY !== 1'b1 || BOUT !== 1'b1) begin
            errors++;
            $display("FAIL hs_bout: O=%0d RDY=%b BOUT=%b, expected 0 1 1", O, LOAD_READY, BOUT);
        end
        tick();
        LOAD_VALID = 1'b0;
        checks++;
        if (O !== 4'd9 || BUSY !== 1'b1 || BOUT !== 1'b0) begin
            errors++;
            $display("FAIL hs_reload: O=%0d BUSY=%b BOUT=%b, expected 9 1 0", O, BUSY, BOUT);
        end
        do_reset();
    endtask

    task automatic test_edges();
        int n;
        bit early;
        EN = 1'b1;
        do_load(4'd15, 1'b0);
        n = 0;
        early = 1'b0;
        while (BOUT !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL edge_full_range: borrow after %0d cycles, expected 16", n);
        end
        tick();
        checks++;
        if (O !== 4'd0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL edge_no_wrap: O=%0d BUSY=%b, expected 0 0", O, BUSY);
        end
        do_load(4'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (BOUT !== 1'b1 || O !== 4'd0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL edge_zero_periodic: BOUT=%b O=%0d at last cycle, expected BOUT=1 every cycle with O=0", BOUT, O);
        end
        EN = 1'b0;
        tick();
        checks++;
        if (BOUT !== 1'b0 || O !== 4'd0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL edge_zero_en0: BOUT=%b O=%0d BUSY=%b, expected 0 0 1", BOUT, O, BUSY);
        end
        do_reset();
    endtask

    initial begin
        RESETN     = 1'b0;
        LOAD_VALID = 1'b0;
        LOAD_DATA  = '0;
        PERIODIC   = 1'b0;
        EN         = 1'b0;
        #12;
        RESETN = 1'b1;
        tick();
        test_reset();
        test_one_shot();
        test_periodic();
        test_enable_gaps();
        test_back_to_back();
        test_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Loadable down-counter timer with a borrow-out, the decrementing counterpart of the team's up-counter with carry-out. A producer loads a start value through a valid/ready handshake. The block then counts down on enabled cycles and pulses BOUT when it borrows through zero. It either stops, or reloads itself for periodic ticks. It sits beside the up-counter as the timeout/tick source for downstream control logic.

## Interface
- WIDTH, 4, counter width in bits (≥ 2)
- CLK  input  1  rising-edge clock
- RESETN  input  1  asynchronous reset, active-low
- LOAD_VALID  input  1  start value offered
- LOAD_READY  output  1  block can accept a start value
- LOAD_DATA  input  WIDTH  start value
- PERIODIC  input  1  mode, sampled with the load: 1 = auto-reload, 0 = one-shot
- EN  input  1  count enable
- O  output  WIDTH  current count
- BOUT  output  1  borrow-out pulse, one cycle
- BUSY  output  1  counter running

## Operation
- States: IDLE, RUN.
- **Reset** (RESETN=0, asynchronous): state=IDLE, O=0, BOUT=0, BUSY=0, LOAD_READY=1, reload register=0, mode register=0.
- **IDLE**
  - LOAD_READY=1, BUSY=0, O holds its value.
  - EN is ignored.
  - A load occurs at an edge with LOAD_VALID=1. On that edge: O←LOAD_DATA, reload register←LOAD_DATA, mode←PERIODIC, state→RUN.
- **RUN**
  - LOAD_READY=0, BUSY=1.
  - LOAD_VALID is ignored; producers must hold it.
  - An edge with EN=0 changes nothing.
  - An edge with EN=1 and O≠0: O←O−1.
  - An edge with EN=1 and O=0 is a borrow: BOUT←1 for the following cycle.
    - Periodic mode: O←reload register, stay in RUN.
    - One-shot mode: O stays 0 (no wrap to all-ones), state→IDLE.
- BOUT←0 on every edge that is not a borrow.
- **Arithmetic**
  - The decrement is computed as a (WIDTH+1)-bit subtraction {0,O} − 1.
  - Bit WIDTH of the result is the borrow.
  - The low WIDTH bits are the next count.
- **Boundary cases**
  - Load value N gives a borrow on the (N+1)-th enabled cycle after the load.
  - LOAD_DATA=0 with PERIODIC=1 gives BOUT on every enabled cycle.
  - LOAD_DATA = all-ones is legal: 2^WIDTH enabled cycles to the borrow.
- **Reset mid-count**: immediate return to the reset state. No BOUT is generated.

## Timing
- LOAD_READY and BUSY decode the state register only. They never depend combinationally on LOAD_VALID or EN.
- O, BOUT and state are registered outputs.
- Load latency: O shows LOAD_DATA and BUSY=1 in the cycle after the accepting edge.
- BOUT latency: high for exactly the one cycle after the borrow edge.
- In one-shot mode, LOAD_READY=1 in that same BOUT cycle. A new load can be accepted at the end of the BOUT cycle, giving back-to-back one-shots with a single idle cycle.
- In periodic mode, O shows the reload value in the same cycle BOUT is high.

## Structure
- Shared package holds:
  - the state enum {IDLE, RUN}
  - the default WIDTH constant
- One sub-module, **sub_bout**: parameterised WIDTH-bit subtract-with-borrow-out.
  - Interface: I0, I1 → O, BOUT.
  - Implemented as a (WIDTH+1)-bit subtract.
  - It is the borrow counterpart of the adder with carry-out.
- Top level: state register, count register, reload register, mode register, registered BOUT, and the next-state mux.

## Test plan
- **Reset values**: drive RESETN low mid-RUN (O=5, WIDTH=4) → O=0, BUSY=0, BOUT=0 and LOAD_READY=1 immediately, without waiting for a clock edge.
- **One-shot**: load 3, PERIODIC=0, EN=1 constant → O=3,2,1,0, then BOUT=1 with BUSY=0 one cycle later; O holds 0 after that.
- **Periodic**: load 2, PERIODIC=1, EN=1 → BOUT high every 3rd cycle for at least 4 periods; O sequence 2,1,0,2,1,0.
- **Enable gaps**: load 2, EN toggling 1,0,1,0,1 → O=2,1,1,0,0, then BOUT; exactly 3 enabled cycles to the borrow.
- **Handshake**:
  - LOAD_VALID held high during RUN → no reload; LOAD_READY=0 throughout.
  - Next load is accepted on the edge at the end of the BOUT cycle in one-shot mode.
- **Edges**:
  - WIDTH=4, load 15 → BOUT after 16 enabled cycles.
  - Load 0 periodic → BOUT every enabled cycle.
  - No wrap to 15 in one-shot mode.
